// File: rtl/axis_frame_src_pkg.sv
// Shared types and constants for the AXI4-Stream frame source.
package axis_frame_src_pkg;

  localparam int unsigned PAT_W  = 2;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned LFSR_W = 16;

  localparam logic [PAT_W-1:0] PAT_LINE10 = 2'd0;
  localparam logic [PAT_W-1:0] PAT_CONST  = 2'd1;
  localparam logic [PAT_W-1:0] PAT_COL    = 2'd2;
  localparam logic [PAT_W-1:0] PAT_LINE   = 2'd3;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

endpackage

// File: rtl/axis_frame_src_pat.sv
// Combinational pixel generator: value of the pixel at (line, col) for a pattern.
module axis_frame_src_pat
  import axis_frame_src_pkg::*;
#(
  parameter int unsigned C_PIXEL_WIDTH = 8,
  parameter int unsigned C_RESO_WIDTH  = 10
) (
  input  logic [PAT_W-1:0]         i_pattern,
  input  logic [C_RESO_WIDTH-1:0]  i_line,
  input  logic [C_RESO_WIDTH-1:0]  i_col,
  input  logic [C_PIXEL_WIDTH-1:0] i_value,
  output logic [C_PIXEL_WIDTH-1:0] o_pixel_c
);

  localparam int unsigned PROD_W = C_RESO_WIDTH + 4;

  logic [PROD_W-1:0] w_line10;

  always_comb begin
    w_line10  = PROD_W'(i_line) * PROD_W'(10) + PROD_W'(i_col);
    o_pixel_c = '0;
    case (i_pattern)
      PAT_LINE10: o_pixel_c = C_PIXEL_WIDTH'(w_line10);
      PAT_CONST:  o_pixel_c = i_value;
      PAT_COL:    o_pixel_c = C_PIXEL_WIDTH'(i_col);
      PAT_LINE:   o_pixel_c = C_PIXEL_WIDTH'(i_line);
      default:    o_pixel_c = '0;
    endcase
  end

endmodule

// File: rtl/axis_frame_src.sv
// AXI4-Stream video frame source (SOF on tuser, EOL on tlast).
// Optional source-side bubbles via LFSR when AXIS_FRAME_SRC_STALL_EN is defined.
module axis_frame_src
  import axis_frame_src_pkg::*;
#(
  parameter int unsigned C_PIXEL_WIDTH = 8,
  parameter int unsigned C_RESO_WIDTH  = 10,
  parameter int unsigned C_GAP_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic [C_RESO_WIDTH-1:0]  cfg_width,
  input  logic [C_RESO_WIDTH-1:0]  cfg_height,
  input  logic [PAT_W-1:0]         cfg_pattern,
  input  logic [C_PIXEL_WIDTH-1:0] cfg_value,
  input  logic [C_GAP_WIDTH-1:0]   cfg_gap,
  output logic                     m_axis_tvalid,
  output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic                     busy,
  output logic                     frame_done,
  output logic [CNT_W-1:0]         frame_cnt
`ifdef AXIS_FRAME_SRC_STALL_EN
  ,
  input  logic                     stall_en
`endif
);

  state_t                   r_state, n_state;
  logic [C_RESO_WIDTH-1:0]  r_width, n_width, r_height, n_height;
  logic [PAT_W-1:0]         r_pattern, n_pattern;
  logic [C_PIXEL_WIDTH-1:0] r_value, n_value;
  logic [C_GAP_WIDTH-1:0]   r_gap, n_gap, r_gap_cnt, n_gap_cnt;
  logic [C_RESO_WIDTH-1:0]  r_col, n_col, r_line, n_line;
  logic                     r_tvalid, n_tvalid, r_tuser, n_tuser, r_tlast, n_tlast;
  logic [C_PIXEL_WIDTH-1:0] r_tdata, n_tdata;
  logic                     r_busy, n_busy, r_done, n_done;
  logic [CNT_W-1:0]         r_frame_cnt, n_frame_cnt;

  logic                     w_can_present;
  logic                     w_last_col, w_last_line;
  logic [C_RESO_WIDTH-1:0]  w_nx_col, w_nx_line, w_width_sel;
  logic [PAT_W-1:0]         w_pattern_sel;
  logic [C_PIXEL_WIDTH-1:0] w_value_sel, w_pix;

`ifdef AXIS_FRAME_SRC_STALL_EN
  logic [LFSR_W-1:0] r_lfsr;

  // Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_lfsr <= LFSR_SEED;
    else         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_can_present = !stall_en || (r_lfsr[1:0] != 2'b00);
`else
  assign w_can_present = 1'b1;
`endif

  // Coordinates of the next beat to present; in IDLE the live config applies.
  always_comb begin
    w_width_sel   = (r_state == S_IDLE) ? cfg_width   : r_width;
    w_pattern_sel = (r_state == S_IDLE) ? cfg_pattern : r_pattern;
    w_value_sel   = (r_state == S_IDLE) ? cfg_value   : r_value;
    w_last_col    = (r_col  == r_width  - C_RESO_WIDTH'(1));
    w_last_line   = (r_line == r_height - C_RESO_WIDTH'(1));
    w_nx_col      = '0;
    w_nx_line     = '0;
    if (r_state == S_ACTIVE) begin
      if (!r_tvalid) begin
        w_nx_col  = r_col;
        w_nx_line = r_line;
      end else if (w_last_col) begin
        w_nx_col  = '0;
        w_nx_line = r_line + C_RESO_WIDTH'(1);
      end else begin
        w_nx_col  = r_col + C_RESO_WIDTH'(1);
        w_nx_line = r_line;
      end
    end
  end

  axis_frame_src_pat #(
    .C_PIXEL_WIDTH (C_PIXEL_WIDTH),
    .C_RESO_WIDTH  (C_RESO_WIDTH)
  ) u_pat (
    .i_pattern (w_pattern_sel),
    .i_line    (w_nx_line),
    .i_col     (w_nx_col),
    .i_value   (w_value_sel),
    .o_pixel_c (w_pix)
  );

  // Next-state and registered-output logic
  always_comb begin
    n_state     = r_state;
    n_width     = r_width;
    n_height    = r_height;
    n_pattern   = r_pattern;
    n_value     = r_value;
    n_gap       = r_gap;
    n_gap_cnt   = r_gap_cnt;
    n_col       = r_col;
    n_line      = r_line;
    n_tvalid    = r_tvalid;
    n_tdata     = r_tdata;
    n_tuser     = r_tuser;
    n_tlast     = r_tlast;
    n_done      = 1'b0;
    n_frame_cnt = r_frame_cnt;

    case (r_state)
      S_IDLE: begin
        if (enable && (cfg_width != '0) && (cfg_height != '0)) begin
          n_width   = cfg_width;
          n_height  = cfg_height;
          n_pattern = cfg_pattern;
          n_value   = cfg_value;
          n_gap     = cfg_gap;
          n_col     = '0;
          n_line    = '0;
          n_state   = S_ACTIVE;
          n_tvalid  = w_can_present;
          if (w_can_present) begin
            n_tdata = w_pix;
            n_tuser = 1'b1;
            n_tlast = (w_width_sel == C_RESO_WIDTH'(1));
          end
        end
      end
      S_ACTIVE: begin
        if (r_tvalid && m_axis_tready) begin
          if (w_last_col && w_last_line) begin
            n_tvalid    = 1'b0;
            n_tdata     = '0;
            n_tuser     = 1'b0;
            n_tlast     = 1'b0;
            n_done      = 1'b1;
            n_frame_cnt = r_frame_cnt + CNT_W'(1);
            n_col       = '0;
            n_line      = '0;
            n_gap_cnt   = r_gap;
            n_state     = (r_gap == '0) ? S_IDLE : S_GAP;
          end else begin
            n_col    = w_nx_col;
            n_line   = w_nx_line;
            n_tvalid = w_can_present;
            if (w_can_present) begin
              n_tdata = w_pix;
              n_tuser = (w_nx_col == '0) && (w_nx_line == '0);
              n_tlast = (w_nx_col == w_width_sel - C_RESO_WIDTH'(1));
            end
          end
        end else if (!r_tvalid && w_can_present) begin
          n_tvalid = 1'b1;
          n_tdata  = w_pix;
          n_tuser  = (w_nx_col == '0) && (w_nx_line == '0);
          n_tlast  = (w_nx_col == w_width_sel - C_RESO_WIDTH'(1));
        end
      end
      S_GAP: begin
        if (r_gap_cnt <= C_GAP_WIDTH'(1)) n_state   = S_IDLE;
        else                              n_gap_cnt = r_gap_cnt - C_GAP_WIDTH'(1);
      end
      default: n_state = S_IDLE;
    endcase

    n_busy = (n_state == S_ACTIVE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_width     <= '0;
      r_height    <= '0;
      r_pattern   <= '0;
      r_value     <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_col       <= '0;
      r_line      <= '0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tuser     <= 1'b0;
      r_tlast     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= n_state;
      r_width     <= n_width;
      r_height    <= n_height;
      r_pattern   <= n_pattern;
      r_value     <= n_value;
      r_gap       <= n_gap;
      r_gap_cnt   <= n_gap_cnt;
      r_col       <= n_col;
      r_line      <= n_line;
      r_tvalid    <= n_tvalid;
      r_tdata     <= n_tdata;
      r_tuser     <= n_tuser;
      r_tlast     <= n_tlast;
      r_busy      <= n_busy;
      r_done      <= n_done;
      r_frame_cnt <= n_frame_cnt;
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tlast  = r_tlast;
  assign busy          = r_busy;
  assign frame_done    = r_done;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_axis_frame_src.sv
// Directed self-checking bench for axis_frame_src (default build, no stall feature).
module tb_axis_frame_src;

  localparam int unsigned PW = 8;
  localparam int unsigned RW = 10;
  localparam int unsigned GW = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          enable;
  logic [RW-1:0] cfg_width, cfg_height;
  logic [1:0]    cfg_pattern;
  logic [PW-1:0] cfg_value;
  logic [GW-1:0] cfg_gap;
  logic          m_axis_tvalid;
  logic [PW-1:0] m_axis_tdata;
  logic          m_axis_tuser, m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          busy, frame_done;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  axis_frame_src #(
    .C_PIXEL_WIDTH (PW),
    .C_RESO_WIDTH  (RW),
    .C_GAP_WIDTH   (GW)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .cfg_width     (cfg_width),
    .cfg_height    (cfg_height),
    .cfg_pattern   (cfg_pattern),
    .cfg_value     (cfg_value),
    .cfg_gap       (cfg_gap),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt)
  );

  typedef struct {
    logic          user;
    logic          last;
    logic [PW-1:0] data;
    int            cyc;
  } beat_t;

  beat_t q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    done_cnt = 0;
  int    ready_mode = 0;
  logic  stalled = 1'b0;
  logic [PW+1:0] held = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive tready and capture accepted beats away from the active edge
  always @(negedge clk) begin
    cyc++;
    m_axis_tready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    if (frame_done) done_cnt++;
    if (stalled) begin
      check("hold_valid", 32'(m_axis_tvalid), 32'd1);
      check("hold_beat", 32'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 32'(held));
    end
    stalled = m_axis_tvalid && !m_axis_tready;
    held    = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (m_axis_tvalid && m_axis_tready)
      q.push_back('{m_axis_tuser, m_axis_tlast, m_axis_tdata, cyc});
  end

  task automatic set_cfg(input int w, input int h, input int p, input int v, input int g);
    cfg_width   = RW'(w);
    cfg_height  = RW'(h);
    cfg_pattern = 2'(p);
    cfg_value   = PW'(v);
    cfg_gap     = GW'(g);
  endtask

  task automatic wait_busy();
    logic ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy) begin ok = 1'b1; break; end
    end
    check("busy_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int   snap = done_cnt;
    logic ok   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != snap) begin ok = 1'b1; break; end
    end
    check("done_timeout", 32'(ok), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_beats(input int n);
    logic ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q.size() >= n) begin ok = 1'b1; break; end
    end
    check("beats_timeout", 32'(ok), 32'd1);
  endtask

  task automatic chk_beat(input string t, input int i, input logic u, input logic l, input int d);
    if (i < q.size()) begin
      check($sformatf("%s_b%0d_user", t, i), 32'(q[i].user), 32'(u));
      check($sformatf("%s_b%0d_last", t, i), 32'(q[i].last), 32'(l));
      check($sformatf("%s_b%0d_data", t, i), 32'(q[i].data), 32'(d));
    end else begin
      check($sformatf("%s_b%0d_missing", t, i), 32'(q.size()), 32'(i + 1));
    end
  endtask

  task automatic run_frame();
    enable = 1'b1;
    wait_busy();
    enable = 1'b0;
    wait_done(500);
  endtask

  int t1_data [12] = '{0, 1, 2, 3, 10, 11, 12, 13, 20, 21, 22, 23};
  int snap_done;

  initial begin
    resetn = 1'b0;
    enable = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata",  32'(m_axis_tdata),  32'd0);
    check("rst_tuser",  32'(m_axis_tuser),  32'd0);
    check("rst_tlast",  32'(m_axis_tlast),  32'd0);
    check("rst_busy",   32'(busy),          32'd0);
    check("rst_done",   32'(frame_done),    32'd0);
    check("rst_cnt",    32'(frame_cnt),     32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // zero width keeps the source idle
    enable = 1'b1;
    repeat (4) @(negedge clk);
    check("zero_w_busy", 32'(busy), 32'd0);
    check("zero_w_valid", 32'(m_axis_tvalid), 32'd0);
    enable = 1'b0;

    // T1: 4x3 line*10+col, full rate
    set_cfg(4, 3, 0, 0, 0);
    q.delete();
    snap_done = done_cnt;
    run_frame();
    repeat (3) @(negedge clk);
    check("t1_nbeats", 32'(q.size()), 32'd12);
    for (int i = 0; i < 12; i++) chk_beat("t1", i, i == 0, (i % 4) == 3, t1_data[i]);
    check("t1_done_pulses", 32'(done_cnt - snap_done), 32'd1);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // T2: same frame with tready 1,0,0,...
    ready_mode = 1;
    q.delete();
    run_frame();
    ready_mode = 0;
    check("t2_nbeats", 32'(q.size()), 32'd12);
    for (int i = 0; i < 12; i++) chk_beat("t2", i, i == 0, (i % 4) == 3, t1_data[i]);
    check("t2_frame_cnt", 32'(frame_cnt), 32'd2);

    // T3: W=1, H=2, constant 0x5A
    set_cfg(1, 2, 1, 8'h5A, 0);
    q.delete();
    run_frame();
    check("t3_nbeats", 32'(q.size()), 32'd2);
    chk_beat("t3", 0, 1'b1, 1'b1, 8'h5A);
    chk_beat("t3", 1, 1'b0, 1'b1, 8'h5A);
    check("t3_frame_cnt", 32'(frame_cnt), 32'd3);

    // T4: gap of 5 between back-to-back frames, col ramp
    set_cfg(2, 1, 2, 0, 5);
    q.delete();
    enable = 1'b1;
    wait_done(200);
    wait_busy();
    enable = 1'b0;
    wait_done(200);
    check("t4_nbeats", 32'(q.size()), 32'd4);
    chk_beat("t4", 0, 1'b1, 1'b0, 0);
    chk_beat("t4", 1, 1'b0, 1'b1, 1);
    chk_beat("t4", 2, 1'b1, 1'b0, 0);
    chk_beat("t4", 3, 1'b0, 1'b1, 1);
    if (q.size() >= 3) check("t4_gap_cycles", 32'(q[2].cyc - q[1].cyc), 32'd7);
    check("t4_frame_cnt", 32'(frame_cnt), 32'd5);

    // T5: width change mid-frame applies to the next frame only
    set_cfg(4, 2, 2, 0, 0);
    q.delete();
    enable = 1'b1;
    wait_busy();
    cfg_width = RW'(8);
    wait_done(200);
    wait_busy();
    enable = 1'b0;
    wait_done(200);
    check("t5_nbeats", 32'(q.size()), 32'd24);
    for (int i = 0; i < 8; i++) chk_beat("t5a", i, i == 0, (i % 4) == 3, i % 4);
    for (int j = 0; j < 16; j++) chk_beat("t5b", j + 8, j == 0, (j % 8) == 7, j % 8);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd7);

    // T6: asynchronous reset mid-frame, then clean restart
    set_cfg(4, 3, 0, 0, 0);
    q.delete();
    enable = 1'b1;
    wait_beats(5);
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t6_rst_tdata",  32'(m_axis_tdata),  32'd0);
    check("t6_rst_tuser",  32'(m_axis_tuser),  32'd0);
    check("t6_rst_tlast",  32'(m_axis_tlast),  32'd0);
    check("t6_rst_busy",   32'(busy),          32'd0);
    check("t6_rst_cnt",    32'(frame_cnt),     32'd0);
    @(negedge clk);
    resetn = 1'b1;
    q.delete();
    wait_beats(1);
    chk_beat("t6", 0, 1'b1, 1'b0, 0);
    check("t6_cnt_restart", 32'(frame_cnt), 32'd0);
    enable = 1'b0;
    wait_done(200);
    check("t6_nbeats", 32'(q.size()), 32'd12);
    check("t6_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_frame_src.md
Name: axis_frame_src

Overview:
AXI4-Stream video transmitter that generates whole frames (SOF on tuser, EOL on tlast) at a programmable resolution and pattern. It is the source end of the stream consumed by the vertical scaler's s_axis port. It is used as a bench stimulus and as an on-chip test-pattern source ahead of the scaler. Pattern 0 produces lines whose pixels differ by 10 from the previous line, matching the scaler's line-pair data check.

Parameters:
C_PIXEL_WIDTH, 8, pixel data width (tdata width)
C_RESO_WIDTH, 10, width of width/height/coordinate counters
C_GAP_WIDTH, 8, width of inter-frame idle-cycle count

Ports:
clk  in  1  clock, all logic rising-edge
resetn  in  1  reset, asynchronous assert, active-low
enable  in  1  level; start/continue generating frames
cfg_width  in  C_RESO_WIDTH  pixels per line, sampled at frame start
cfg_height  in  C_RESO_WIDTH  lines per frame, sampled at frame start
cfg_pattern  in  2  0=line*10+col, 1=constant cfg_value, 2=col ramp, 3=line ramp; sampled at frame start
cfg_value  in  C_PIXEL_WIDTH  constant for pattern 1
cfg_gap  in  C_GAP_WIDTH  idle cycles inserted after each frame
m_axis_tvalid  out  1  pixel valid
m_axis_tdata  out  C_PIXEL_WIDTH  pixel
m_axis_tuser  out  1  first pixel of frame
m_axis_tlast  out  1  last pixel of line
m_axis_tready  in  1  sink ready
busy  out  1  high from frame start to last-pixel acceptance
frame_done  out  1  one-cycle pulse after last pixel of frame accepted
frame_cnt  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset (async, resetn=0): all outputs 0; state IDLE; counters 0; latched config 0.
- FSM:
  - IDLE: when enable=1 and cfg_width!=0 and cfg_height!=0, latch the config and go ACTIVE. Zero width or height keeps the FSM in IDLE.
  - ACTIVE: stream pixels.
  - GAP: count down the latched gap, then return to IDLE.
- Latency: first tvalid appears 1 cycle after the IDLE->ACTIVE transition (latch cycle). tvalid is registered.
- Handshake: a beat transfers on tvalid&&tready.
  - tvalid, once asserted, stays high until the beat transfers.
  - tdata/tuser/tlast are stable while tvalid&&!tready.
  - The next beat is presented the same cycle as the transfer, so throughput is 1 pixel/clk with tready=1.
- Counters:
  - col runs 0..W-1 and line runs 0..H-1, advancing on transfer.
  - col wraps to 0 and line increments on tlast transfer.
- Flags: tuser=1 only when col=0 and line=0. tlast=1 when col=W-1. For W=1, every beat has tlast=1 and the first beat also has tuser=1.
- Data: pattern 0 = (line*10+col) mod 2^C_PIXEL_WIDTH. Pattern 2 = col truncated to C_PIXEL_WIDTH. Pattern 3 = line truncated to C_PIXEL_WIDTH.
- End of frame:
  - On transfer of col=W-1, line=H-1: tvalid drops next cycle, frame_done pulses, frame_cnt increments.
  - If cfg_gap=0, go straight to IDLE; otherwise go to GAP.
- Config changes mid-frame are ignored; they take effect at the next frame start.
- enable deasserted mid-frame: the current frame completes, then the FSM stays in IDLE.
- Reset mid-frame: immediate abort. No partial EOL or SOF is emitted afterward, and the next frame restarts with tuser.
- busy = state ACTIVE.

Optional Feature:
AXIS_FRAME_SRC_STALL_EN
- Defined: a 16-bit LFSR (seed 0xACE1, taps 16,14,13,11) advances every clk. A new beat may only be presented when lfsr[1:0]!=0, so roughly 25% of source-side bubbles are inserted. An already-asserted tvalid is never withdrawn. Adds input port stall_en (1 bit); stall_en=0 disables the bubbles.
- Undefined: no LFSR, no stall_en port, and the source runs at full rate.

Decomposition:
- Shared package axis_frame_src_pkg holds:
  - pattern codes PAT_LINE10=0, PAT_CONST=1, PAT_COL=2, PAT_LINE=3
  - FSM state encoding S_IDLE, S_ACTIVE, S_GAP
  - LFSR seed constant
- One sub-module, axis_frame_src_pat: combinational pixel function of (pattern, line, col, value). This keeps the FSM and handshake logic separate from data generation.

Test Plan:
1. W=4, H=3, pattern 0, gap=0, tready=1 → 12 consecutive beats with data 0,1,2,3,10,11,12,13,20,21,22,23. tuser on beat 0 only; tlast on beats 3, 7, 11. frame_done pulses once and frame_cnt=1.
2. Same config with tready toggling 1,0,0,1,... → identical beat sequence. tdata/tuser/tlast unchanged during every tvalid&&!tready cycle.
3. W=1, H=2, pattern 1, value=0x5A → 2 beats of 0x5A. Beat 0 has tuser=1 and tlast=1; beat 1 has tlast=1.
4. cfg_gap=5, enable held high → exactly 5 cycles in GAP plus 1 IDLE-latch cycle between the final tlast transfer and the next tvalid, which carries tuser=1.
5. Change cfg_width from 4 to 8 mid-frame → the current frame still ends at 4 pixels/line, and the next frame uses 8.
6. Assert resetn=0 at beat 5 of a 4x3 frame → outputs are 0 immediately (asynchronously). After release with enable=1, the first beat has tuser=1 and data 0, and frame_cnt=0.
